// File: rtl/m3_pkg.sv
// Shared definitions for the serial multiple-of-3 sequencer: FSM states,
// residue constants and the one-bit residue update.
package m3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    // Appending bit b to a value with residue r gives residue (2r + b) mod 3.
    function automatic logic [1:0] m3_next(input logic [1:0] r, input logic b);
        logic [2:0] s;
        s = {r, 1'b0} + {2'b00, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/m3_residue.sv
// Two-bit mod-3 residue register fed one serial bit per enable strobe.
module m3_residue
    import m3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] residue
);

    logic [1:0] res_q;
    logic [1:0] res_d;

    always_comb begin
        res_d = res_q;
        if (clr) begin
            res_d = R0;
        end else if (en) begin
            res_d = m3_next(res_q, bit_in);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= R0;
        end else begin
            res_q <= res_d;
        end
    end

    assign residue = res_q;

endmodule

// File: rtl/m3_stream_sched.sv
// Captures a word on start, streams it MSB-first into the mod-3 residue
// register at one bit per TICK_DIV clocks, then pulses done with the verdict.
module m3_stream_sched
    import m3_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = 4000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             is_mult3,
    output logic [1:0]       residue,
    output logic             bit_out,
    output logic             tick
);

    localparam int unsigned BC_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  presc_q;
    logic [CNT_W-1:0]  presc_d;
    logic [BC_W-1:0]   bitcnt_q;
    logic [BC_W-1:0]   bitcnt_d;
    logic [WIDTH-1:0]  shreg_q;
    logic [WIDTH-1:0]  shreg_d;
    logic              bit_out_q;
    logic              bit_out_d;
    logic              is_mult3_q;
    logic              is_mult3_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;
    logic              tick_q;
    logic              tick_d;

    logic              accept;
    logic              consume;
    logic              last_bit;
    logic [1:0]        res_cur;

    assign accept   = (state_q == ST_IDLE) && start;
    assign consume  = (state_q == ST_SHIFT) && tick_q;
    assign last_bit = consume && (bitcnt_q == BC_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags track the next state so
    // they line up with state_q after the edge.
    always_comb begin
        presc_d    = '0;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        bit_out_d  = bit_out_q;
        is_mult3_d = is_mult3_q;

        if (state_q == ST_SHIFT) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + CNT_W'(1);
        end

        if (accept) begin
            shreg_d   = din;
            bit_out_d = din[WIDTH-1];
            bitcnt_d  = BC_W'(WIDTH);
        end else if (consume) begin
            shreg_d   = shreg_q << 1;
            bit_out_d = shreg_d[WIDTH-1];
            bitcnt_d  = bitcnt_q - BC_W'(1);
        end

        if (last_bit) begin
            is_mult3_d = (m3_next(res_cur, bit_out_q) == R0);
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        tick_d = (state_d == ST_SHIFT) && (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            bit_out_q  <= 1'b0;
            is_mult3_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            bit_out_q  <= bit_out_d;
            is_mult3_q <= is_mult3_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
        end
    end

    m3_residue u_residue (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (consume),
        .bit_in  (bit_out_q),
        .residue (res_cur)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign is_mult3 = is_mult3_q;
    assign residue  = res_cur;
    assign bit_out  = bit_out_q;
    assign tick     = tick_q;

endmodule
